// File: rtl/multi_pwm_keyctl.sv
// Multi-channel PWM generator with key-driven, period-synchronised duty control.
// Keys act on the selected channel's shadow duty; active duties reload at each period boundary.
module multi_pwm_keyctl #(
  parameter int CH         = 4,
  parameter int DW         = 8,
  parameter int PRESCALE   = 195,
  parameter int TICK_CYC   = 50000,
  parameter int HOLD_MS    = 500,
  parameter int REPEAT_MS  = 100,
  parameter int STEP_BIG   = 10,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                               CLK,
  input  logic                               RSTn,
  input  logic [4:0]                         key_in,
  output logic [CH-1:0]                      pwm_out,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] sel,
  output logic [DW-1:0]                      duty_sel,
  output logic                               busy
);

  localparam int SW     = (CH > 1) ? $clog2(CH) : 1;
  localparam int PRE_W  = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam int TICK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int MS_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int MS_W   = (MS_MAX > 0) ? $clog2(MS_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW] ? {DW{1'b1}} : s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} - {1'b0, b};
    return s[DW] ? {DW{1'b0}} : s[DW-1:0];
  endfunction

  state_t            state, state_nxt;
  logic [2:0]        kidx, kidx_win, act_key;
  logic              key_held, do_act, ms_clr;
  logic [TICK_W-1:0] tick_cnt;
  logic [MS_W-1:0]   ms_cnt;
  logic              tick_wrap, hold_done, rep_done;
  logic [PRE_W-1:0]  pre;
  logic [DW-1:0]     phase;
  logic              pre_wrap, boundary;
  logic [DW-1:0]     shadow [CH];
  logic [DW-1:0]     duty   [CH];

  // Key decode: lowest pressed index wins
  always_comb begin
    kidx_win = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (key_in[i]) kidx_win = 3'(i);
    end
  end

  assign key_held  = key_in[kidx];
  assign act_key   = (state == IDLE) ? kidx_win : kidx;
  assign tick_wrap = (tick_cnt == TICK_W'(TICK_CYC - 1));
  assign hold_done = tick_wrap && (ms_cnt == MS_W'(HOLD_MS - 1));
  assign rep_done  = tick_wrap && (ms_cnt == MS_W'(REPEAT_MS - 1));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      busy  <= 1'b0;
      kidx  <= 3'd0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      if (state == IDLE && (|key_in)) kidx <= kidx_win;
    end
  end

  always_comb begin
    state_nxt = state;
    do_act    = 1'b0;
    ms_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (|key_in) begin
          do_act    = 1'b1;
          ms_clr    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!key_held) begin
          state_nxt = IDLE;
        end else if (hold_done && kidx >= 3'd1 && kidx <= 3'd3) begin
          do_act    = 1'b1;
          ms_clr    = 1'b1;
          state_nxt = REPEAT;
        end
      end
      REPEAT: begin
        if (!key_held) begin
          state_nxt = IDLE;
        end else if (rep_done) begin
          do_act = 1'b1;
          ms_clr = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ms timebase: idle while no key is being tracked
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tick_cnt <= '0;
      ms_cnt   <= '0;
    end else if (state == IDLE || ms_clr) begin
      tick_cnt <= '0;
      ms_cnt   <= '0;
    end else if (tick_wrap) begin
      tick_cnt <= '0;
      ms_cnt   <= ms_cnt + MS_W'(1);
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Actions on the selected channel's shadow duty
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sel <= '0;
      for (int c = 0; c < CH; c++) shadow[c] <= '0;
    end else if (do_act) begin
      case (act_key)
        3'd0: shadow[sel] <= {1'b1, {(DW-1){1'b0}}};
        3'd1: shadow[sel] <= sat_add(shadow[sel], DW'(STEP_BIG));
        3'd2: shadow[sel] <= sat_sub(shadow[sel], DW'(STEP_BIG));
        3'd3: shadow[sel] <= sat_add(shadow[sel], DW'(1));
        3'd4: sel <= (sel == SW'(CH - 1)) ? '0 : sel + SW'(1);
        default: ;
      endcase
    end
  end

  assign duty_sel = shadow[sel];

  // PWM timebase and period-boundary reload of active duties
  assign pre_wrap = (pre == PRE_W'(PRESCALE));
  assign boundary = pre_wrap && (phase == {DW{1'b1}});

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pre   <= '0;
      phase <= '0;
      for (int c = 0; c < CH; c++) duty[c] <= '0;
    end else begin
      pre <= pre_wrap ? '0 : pre + PRE_W'(1);
      if (pre_wrap) phase <= phase + DW'(1);
      if (boundary) begin
        for (int c = 0; c < CH; c++) duty[c] <= shadow[c];
      end
    end
  end

  always_comb begin
    pwm_out = '0;
    for (int c = 0; c < CH; c++) begin
      pwm_out[c] = (ACTIVE_LOW != 0) ? !(phase < duty[c]) : (phase < duty[c]);
    end
  end

endmodule

// File: tb/tb_multi_pwm_keyctl.sv
// Bench for multi_pwm_keyctl: directed scenarios plus randomized key traffic,
// every cycle compared against an event-level reference model.
module tb_multi_pwm_keyctl;

  localparam int CH = 4, DW = 4, PRESCALE = 1, TICK_CYC = 10;
  localparam int HOLD_MS = 3, REPEAT_MS = 2, STEP_BIG = 3;
  localparam int STEPS  = PRESCALE + 1;
  localparam int PERIOD = STEPS * (1 << DW);
  localparam int HT     = HOLD_MS * TICK_CYC;
  localparam int RT     = REPEAT_MS * TICK_CYC;
  localparam int MAXD   = (1 << DW) - 1;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic [4:0]    key_in = '0;
  logic [CH-1:0] pwm_out;
  logic [1:0]    sel;
  logic [DW-1:0] duty_sel;
  logic          busy;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  multi_pwm_keyctl #(
    .CH(CH), .DW(DW), .PRESCALE(PRESCALE), .TICK_CYC(TICK_CYC),
    .HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS), .STEP_BIG(STEP_BIG), .ACTIVE_LOW(1)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .key_in(key_in), .pwm_out(pwm_out),
    .sel(sel), .duty_sel(duty_sel), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: actions happen at press, at press+HT, then every RT
  int m_shadow [CH];
  int m_old    [CH];
  int m_active [CH];
  int m_sel, m_cyc, m_key, m_age;

  task automatic m_act(input int k);
    case (k)
      0: m_shadow[m_sel] = 1 << (DW - 1);
      1: m_shadow[m_sel] = (m_shadow[m_sel] + STEP_BIG > MAXD) ? MAXD : m_shadow[m_sel] + STEP_BIG;
      2: m_shadow[m_sel] = (m_shadow[m_sel] - STEP_BIG < 0) ? 0 : m_shadow[m_sel] - STEP_BIG;
      3: m_shadow[m_sel] = (m_shadow[m_sel] + 1 > MAXD) ? MAXD : m_shadow[m_sel] + 1;
      4: m_sel = (m_sel + 1) % CH;
      default: ;
    endcase
  endtask

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int c = 0; c < CH; c++) begin
        m_shadow[c] = 0;
        m_active[c] = 0;
      end
      m_sel = 0; m_cyc = 0; m_key = -1; m_age = 0;
    end else begin
      m_old = m_shadow;
      if (m_key < 0) begin
        if (key_in != 0) begin
          for (int i = 4; i >= 0; i--) if (key_in[i]) m_key = i;
          m_age = 0;
          m_act(m_key);
        end
      end else if (!key_in[m_key]) begin
        m_key = -1;
      end else begin
        m_age++;
        if (m_key >= 1 && m_key <= 3 && m_age >= HT && (m_age - HT) % RT == 0) m_act(m_key);
      end
      if (m_cyc % PERIOD == PERIOD - 1) m_active = m_old;
      m_cyc++;
    end
  end

  function automatic logic [CH-1:0] m_pwm();
    int ph;
    logic [CH-1:0] r;
    ph = (m_cyc / STEPS) % (1 << DW);
    for (int c = 0; c < CH; c++) r[c] = !(ph < m_active[c]);
    return r;
  endfunction

  always @(negedge CLK) begin
    if (RSTn && chk_en) begin
      chk("pwm", 32'(pwm_out), 32'(m_pwm()));
      chk("sel", 32'(sel), 32'(m_sel));
      chk("duty", 32'(duty_sel), 32'(m_shadow[m_sel]));
      chk("busy", 32'(busy), 32'(m_key >= 0));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic tap(input int k);
    key_in = 5'(1 << k);
    cyc(1);
    key_in = '0;
    cyc(4);
  endtask

  task automatic count_low(input int ch, output int lows, output bit others_hi);
    lows = 0;
    others_hi = 1'b1;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge CLK);
      if (!pwm_out[ch]) lows++;
      for (int c = 0; c < CH; c++) if (c != ch && !pwm_out[c]) others_hi = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    bit oth;
    logic [4:0] k;
    int hold, gap;

    #1;
    chk("rst_pwm", 32'(pwm_out), 32'hf);
    chk("rst_busy", 32'(busy), 0);
    cyc(2);
    RSTn = 1'b1;
    chk_en = 1'b1;

    // 1. idle
    cyc(200);
    chk("idle_pwm", 32'(pwm_out), 32'hf);
    chk("idle_duty", 32'(duty_sel), 0);
    chk("idle_sel", 32'(sel), 0);
    chk("idle_busy", 32'(busy), 0);

    // 2. mid duty on channel 0
    key_in = 5'b00001;
    cyc(1);
    chk("k0_duty", 32'(duty_sel), 8);
    cyc(4);
    key_in = '0;
    cyc(40);
    count_low(0, lows, oth);
    chk("k0_lowcnt", 32'(lows), 16);
    chk("k0_others", 32'(oth), 1);

    // 3. auto-repeat with saturation
    key_in = 5'b00010;
    cyc(1);
    chk("rep_0", 32'(duty_sel), 11);
    cyc(30);
    chk("rep_30", 32'(duty_sel), 14);
    cyc(20);
    chk("rep_50", 32'(duty_sel), 15);
    cyc(20);
    chk("rep_70", 32'(duty_sel), 15);
    cyc(9);
    key_in = '0;
    cyc(1);
    chk("rel_busy", 32'(busy), 0);
    cyc(5);

    // 4. saturation at zero, fine step
    tap(0); tap(2); tap(2);
    chk("set2", 32'(duty_sel), 2);
    tap(2);
    chk("sub_sat", 32'(duty_sel), 0);
    tap(3);
    chk("inc1", 32'(duty_sel), 1);

    // 5. channel select
    tap(4); chk("sel1", 32'(sel), 1);
    tap(4); chk("sel2", 32'(sel), 2);
    tap(4); chk("sel3", 32'(sel), 3);
    tap(4); chk("sel0", 32'(sel), 0);
    key_in = 5'b10000;
    cyc(100);
    key_in = '0;
    cyc(3);
    chk("sel_hold", 32'(sel), 1);

    // 6. priority and deferred duty
    key_in = 5'b00110;
    cyc(1);
    chk("prio", 32'(duty_sel), 3);
    chk("defer", 32'(pwm_out[1]), 1);
    cyc(3);
    key_in = '0;
    cyc(64);
    count_low(1, lows, oth);
    chk("ch1_lowcnt", 32'(lows), 6);

    // async reset mid-REPEAT
    key_in = 5'b00010;
    cyc(45);
    chk("pre_rst_busy", 32'(busy), 1);
    #2 RSTn = 1'b0;
    #1;
    chk("arst_pwm", 32'(pwm_out), 32'hf);
    chk("arst_sel", 32'(sel), 0);
    chk("arst_duty", 32'(duty_sel), 0);
    chk("arst_busy", 32'(busy), 0);
    key_in = '0;
    cyc(2);
    RSTn = 1'b1;
    cyc(3);

    // randomized traffic
    for (int it = 0; it < 50; it++) begin
      if ($urandom_range(0, 9) < 7) k = 5'(1 << $urandom_range(0, 4));
      else k = 5'($urandom_range(1, 31));
      hold = $urandom_range(1, 90);
      key_in = k;
      cyc(hold / 2 + 1);
      if ($urandom_range(0, 3) == 0) key_in = k ^ 5'($urandom_range(0, 31));
      cyc(hold - hold / 2);
      key_in = '0;
      gap = $urandom_range(0, 8);
      cyc(gap);
    end
    cyc(40);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_pwm_keyctl.md
Name: multi_pwm_keyctl

Overview:
Parametrised multi-channel PWM generator with key-driven duty control. It takes debounced key levels and applies one action on each press. Holding a key gives auto-repeat after a hold delay. Duty changes are double-buffered so they apply only at a PWM period boundary, which gives glitch-free outputs. It sits between the key debounce modules and LED/buzzer pins, one channel per load.

Parameters:
CH, 4, number of PWM channels (1..16)
DW, 8, duty/phase width; PWM period = 2^DW steps
PRESCALE, 195, one PWM step lasts PRESCALE+1 clocks
TICK_CYC, 50000, clocks per 1 ms timebase tick
HOLD_MS, 500, ms a key must stay held before the first repeat
REPEAT_MS, 100, ms between repeats after HOLD_MS
STEP_BIG, 10, coarse duty step (< 2^DW)
ACTIVE_LOW, 1, 1: output driven 0 while active (buzzer); 0: driven 1 while active (LED)

Ports:
CLK  in  1  system clock; single clock domain
RSTn  in  1  asynchronous, active-low reset
key_in  in  5  debounced key levels, synchronous to CLK, high = pressed: [0] duty=mid, [1] +STEP_BIG, [2] -STEP_BIG, [3] +1, [4] select next channel
pwm_out  out  CH  PWM outputs, polarity per ACTIVE_LOW
sel  out  $clog2(CH) (min 1)  currently selected channel
duty_sel  out  DW  shadow duty of selected channel
busy  out  1  high while the FSM is not IDLE

Behaviour:
- Reset (async, any time including mid-hold): all shadow and active duties = 0, sel = 0, FSM = IDLE, all counters = 0, busy = 0, pwm_out = all inactive (all 1 when ACTIVE_LOW=1).
- Prescaler: pre counts 0..PRESCALE, then wraps. Phase counter (DW bits) increments when pre==PRESCALE and wraps 2^DW-1 -> 0.
- Period boundary: pre==PRESCALE and phase==2^DW-1. On that edge every active duty[c] <= shadow[c].
- Channel c is active when phase < active duty[c]. Duty 0 = never active. Duty 2^DW-1 = active on all steps except the last.
- Key decode: among pressed keys, the lowest index wins (fixed priority). The winning index is latched as kidx.
- FSM states: IDLE, HOLD, REPEAT.
  - IDLE: on any key_in bit high, perform action(kidx) on that same edge, clear the ms counters, go to HOLD.
  - HOLD: if key_in[kidx]==0, go to IDLE with no action. If ms count reaches HOLD_MS and kidx is in 1..3, perform the action, clear the ms counters, go to REPEAT. Keys 0 and 4 are one-shot and stay in HOLD until released.
  - REPEAT: if key_in[kidx]==0, go to IDLE. Every REPEAT_MS, perform the action and clear the ms counter.
  - A change of pressed keys while in HOLD or REPEAT is ignored until kidx is released.
- ms timebase: the tick counter counts 0..TICK_CYC-1 and runs only when not IDLE. It is cleared whenever the ms counter is cleared. The ms counter is wide enough for max(HOLD_MS, REPEAT_MS).
- Actions, applied to shadow[sel] only:
  - k0 sets shadow = 2^(DW-1).
  - k1 and k3 add STEP_BIG or 1, saturating at 2^DW-1. Compute at DW+1 bits.
  - k2 subtracts STEP_BIG, saturating at 0.
  - k4 sets sel = (sel==CH-1) ? 0 : sel+1.
- Latency: shadow and duty_sel update on the edge that performs the action. pwm_out reflects the new duty from the next period boundary onward.
- Simultaneous action and period boundary on the same edge: active duty takes the old shadow; the new value applies at the following boundary.
- busy = (state != IDLE), registered.

Test Plan:
Bench parameters: CH=4, DW=4, PRESCALE=1, TICK_CYC=10, HOLD_MS=3, REPEAT_MS=2, STEP_BIG=3, ACTIVE_LOW=1.
1. Reset released, no keys -> pwm_out=4'b1111, duty_sel=0, sel=0, busy=0 for 200 cycles. Assert RSTn low mid-REPEAT -> all outputs return to reset values immediately.
2. Pulse key_in[0] for 5 cycles -> duty_sel=8 on the first edge. From the next period boundary, pwm_out[0] is low for 16 clocks and high for 16 clocks of each 32-clock period; channels 1-3 stay 1.
3. From duty 8, hold key_in[1] for 80 cycles -> duty_sel 11 immediately, 14 at +30 cycles, 15 at +50 cycles, still 15 at +70 (saturated). Release -> busy=0 next cycle.
4. Set duty 2, then tap key_in[2] -> duty_sel=0 (saturated). Tap key_in[3] -> 1.
5. Four separate taps of key_in[4] -> sel 1,2,3,0. Hold key_in[4] 100 cycles -> sel advances exactly once.
6. key_in[1] and key_in[2] rising together -> +3 applied, not -3. Change duty mid-period -> pwm_out unchanged until the period boundary.
